// File: rtl/wb_queue.sv
// Writeback queue: buffers multi-cycle results in order and retires one result per cycle, with ALU priority.
// Optional WB_QUEUE_BYPASS_EN lets a push into an idle, empty queue go straight to the output stage.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  output logic [4:0]               rd_wb,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_en_5,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic alu_win;
  logic empty;
  logic push_nz;
  logic pop;
  logic byp;
  logic store;

  assign in_ready = (count != FULL);
  assign empty    = (count == '0);
  assign alu_win  = alu_valid && (alu_rd != 5'd0);
  assign push_nz  = in_valid && in_ready && (in_rd != 5'd0);
  assign pop      = !alu_win && !empty;

`ifdef WB_QUEUE_BYPASS_EN
  assign byp = !alu_win && empty && push_nz;
`else
  assign byp = 1'b0;
`endif

  // x0 results are accepted by the handshake but never occupy a slot
  assign store = push_nz && !byp;

  always_ff @(posedge clk) begin
    if (store) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_5 <= 1'b0;
      rd_wb   <= '0;
      wb_data <= '0;
    end else begin
      unique case (1'b1)
        alu_win: begin
          wb_en_5 <= 1'b1;
          rd_wb   <= alu_rd;
          wb_data <= alu_data;
        end
        pop: begin
          wb_en_5 <= 1'b1;
          rd_wb   <= mem_rd[rd_ptr];
          wb_data <= mem_data[rd_ptr];
        end
        byp: begin
          wb_en_5 <= 1'b1;
          rd_wb   <= in_rd;
          wb_data <= in_data;
        end
        default: begin
          wb_en_5 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a queue-level reference model predicts retirements,
// a negedge monitor compares DUT outputs against them.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      in_rd = '0;
  logic [XLEN-1:0] in_data = '0;
  logic [4:0]      rd_wb;
  logic [XLEN-1:0] wb_data;
  logic            wb_en_5;
  logic [2:0]      count;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } res_t;

  res_t mq[$];
  res_t sb[$];
  bit   exp_en = 1'b0;
  res_t held = '0;
  int   tests = 0;
  int   fails = 0;

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data),
    .rd_wb(rd_wb), .wb_data(wb_data), .wb_en_5(wb_en_5),
    .count(count)
  );

  always #5 clk = ~clk;

  // reference model: FIFO as a queue, retirement decided by priority rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      sb.delete();
      exp_en = 1'b0;
    end else begin
      bit   alu_win;
      bit   push;
      res_t r;
      alu_win = alu_valid && alu_rd != 0;
      push = in_valid && (mq.size() != DEPTH) && in_rd != 0;
      exp_en = 1'b1;
      if (alu_win) begin
        r.rd = alu_rd; r.data = alu_data;
        sb.push_back(r);
      end else if (mq.size() > 0) begin
        sb.push_back(mq.pop_front());
`ifdef WB_QUEUE_BYPASS_EN
      end else if (push) begin
        r.rd = in_rd; r.data = in_data;
        sb.push_back(r);
        push = 1'b0;
`endif
      end else begin
        exp_en = 1'b0;
      end
      if (push) begin
        r.rd = in_rd; r.data = in_data;
        mq.push_back(r);
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    res_t e;
    if (!rst) held = '0;
    tests++;
    if (in_ready !== (mq.size() != DEPTH)) begin
      fails++;
      $display("FAIL in_ready: got %b want %b", in_ready, mq.size() != DEPTH);
    end
    tests++;
    if (count !== 3'(mq.size())) begin
      fails++;
      $display("FAIL count: got %0d want %0d", count, mq.size());
    end
    tests++;
    if (wb_en_5 !== exp_en) begin
      fails++;
      $display("FAIL wb_en_5: got %b want %b", wb_en_5, exp_en);
    end
    if (wb_en_5 === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL retire: got rd=%0d data=%h want none", rd_wb, wb_data);
      end else begin
        e = sb.pop_front();
        if (rd_wb !== e.rd || wb_data !== e.data) begin
          fails++;
          $display("FAIL retire: got rd=%0d data=%h want rd=%0d data=%h",
                   rd_wb, wb_data, e.rd, e.data);
        end
        held = e;
      end
    end else begin
      tests++;
      if (rd_wb !== held.rd || wb_data !== held.data) begin
        fails++;
        $display("FAIL hold: got rd=%0d data=%h want rd=%0d data=%h",
                 rd_wb, wb_data, held.rd, held.data);
      end
    end
  end

  task automatic cyc(input bit av, input logic [4:0] ard,
                     input bit iv, input logic [4:0] ird);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = $urandom;
    in_valid  = iv;
    in_rd     = ird;
    in_data   = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic mid_reset;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || wb_en_5 !== 1'b0 || rd_wb !== 5'd0 || wb_data !== '0) begin
      fails++;
      $display("FAIL async_reset: got count=%0d en=%b rd=%0d data=%h want 0 0 0 0",
               count, wb_en_5, rd_wb, wb_data);
    end
    alu_valid = 1'b0;
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);

    // single push, then idle
    cyc(1'b0, 5'd0, 1'b1, 5'd5);
    idle(3);

    // fill while ALU busy; rd=6 must stall
    for (int i = 2; i <= 6; i++) cyc(1'b1, 5'd1, 1'b1, 5'(i));
    cyc(1'b1, 5'd1, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 1'b1, 5'd6);
    idle(6);

    // priority: FIFO holds 7, ALU writes 8
    cyc(1'b1, 5'd9, 1'b1, 5'd7);
    cyc(1'b1, 5'd8, 1'b0, 5'd0);
    idle(3);

    // x0 filtering
    cyc(1'b0, 5'd0, 1'b1, 5'd0);
    cyc(1'b1, 5'd0, 1'b0, 5'd0);
    idle(2);

    // full, then ALU idle with in_valid held
    for (int i = 10; i < 14; i++) cyc(1'b1, 5'd1, 1'b1, 5'(i));
    for (int i = 14; i < 20; i++) cyc(1'b0, 5'd0, 1'b1, 5'(i));
    idle(6);

    // count=3 then async reset between edges
    for (int i = 20; i < 23; i++) cyc(1'b1, 5'd1, 1'b1, 5'(i));
    mid_reset();
    idle(5);

    // randomized phases with varying ALU/push pressure
    for (int p = 0; p < 12; p++) begin
      int pa = $urandom_range(90);
      int pi = $urandom_range(100, 20);
      for (int i = 0; i < 200; i++) begin
        logic [4:0] ar = 5'($urandom);
        logic [4:0] ir = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        cyc($urandom_range(99) < pa, ar, $urandom_range(99) < pi, ir);
      end
      if (p == 5) mid_reset();
      idle(8);
    end

    tests++;
    if (sb.size() != 0 || mq.size() != 0) begin
      fails++;
      $display("FAIL drain: got sb=%0d mq=%0d want 0 0", sb.size(), mq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
